// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared constants and types for the tl_mem_burst slice.
//   - TileLink opcode constants for the A channel (requests) and the
//     D channel (responses)
//   - FSM state encoding used by tl_mem_burst
//   - rem_init(): number of beats that follow the first beat of a burst
// -----------------------------------------------------------------------------
package tl_pkg;

    // A-channel request opcodes
    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    // D-channel response opcodes
    localparam logic [2:0] ACK         = 3'd0;
    localparam logic [2:0] ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        WACK   = 2'd2,
        RBURST = 2'd3
    } state_t;

    // Returns beats-1 for a transfer of 2^size bytes on a bus carrying
    // 2^lb bytes per beat. A transfer narrower than the bus is one beat.
    // The result saturates at 255 so an 8-bit counter covers 256 beats.
    function automatic logic [7:0] rem_init(input logic [7:0] size, input int lb);
        int sz;
        sz = int'(size);
        if (sz <= lb) begin
            return 8'd0;
        end
        if (sz - lb >= 8) begin
            return 8'hFF;
        end
        return 8'((1 << (sz - lb)) - 1);
    endfunction

endpackage

// File: rtl/tl_mem_burst_if.sv
// -----------------------------------------------------------------------------
// tl_mem_burst_if
// TileLink-UL style A/D channel bundle between a master and tl_mem_burst.
// Parameters: DW data width, AW address width, SRC_W source-ID width.
// A channel (master -> slave): a_opcode, a_param, a_size, a_source,
//   a_address, a_mask, a_data, a_corrupt, a_valid; a_ready back.
// D channel (slave -> master): d_opcode, d_param, d_size, d_source, d_sink,
//   d_denied, d_data, d_corrupt, d_valid; d_ready back.
// -----------------------------------------------------------------------------
interface tl_mem_burst_if #(
    parameter int DW    = 128,
    parameter int AW    = 32,
    parameter int SRC_W = 3
);
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [7:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [AW-1:0]    a_address;
    logic [DW/8-1:0]  a_mask;
    logic [DW-1:0]    a_data;
    logic             a_corrupt;
    logic             a_valid;
    logic             a_ready;

    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [7:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic [2:0]       d_sink;
    logic             d_denied;
    logic [DW-1:0]    d_data;
    logic             d_corrupt;
    logic             d_valid;
    logic             d_ready;

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask,
               a_data, a_corrupt, a_valid, d_ready,
        output a_ready, d_opcode, d_param, d_size, d_source, d_sink,
               d_denied, d_data, d_corrupt, d_valid
    );

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask,
               a_data, a_corrupt, a_valid, d_ready,
        input  a_ready, d_opcode, d_param, d_size, d_source, d_sink,
               d_denied, d_data, d_corrupt, d_valid
    );
endinterface

// File: rtl/tl_mem_ram.sv
// -----------------------------------------------------------------------------
// tl_mem_ram
// DEPTH x DW storage with per-byte write enables, one write port and one
// registered read port (read data appears the cycle after i_raddr).
// Ports: i_clk clock; i_we byte-lane write enables; i_waddr/i_wdata write
//   port; i_raddr read address; o_rdata registered read data.
// Contents are not reset.
// -----------------------------------------------------------------------------
module tl_mem_ram #(
    parameter int DW    = 128,
    parameter int DEPTH = 4096
) (
    input  logic                     i_clk,
    input  logic [DW/8-1:0]          i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DW-1:0]            o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int l = 0; l < DW/8; l++) begin
            if (i_we[l]) begin
                r_mem[i_waddr][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/tl_mem_burst.sv
// -----------------------------------------------------------------------------
// tl_mem_burst
// TileLink-UL burst memory slave: PutFullData / PutPartialData bursts are
// written into a DEPTH x DW RAM, Get bursts are read back beat by beat.
// Other opcodes are acknowledged as a single-beat write with no RAM update.
// Ports: clk sole clock; rst_n synchronous active-low reset;
//   bus (tl_mem_burst_if.slave) carries the A and D channels.
// Optional feature: define TL_MEM_DENY_EN to deny requests whose address
//   lies beyond the RAM (no write, d_denied=1, Get beats corrupt with zero
//   data). Without it every address wraps modulo DEPTH words.
// -----------------------------------------------------------------------------
module tl_mem_burst
    import tl_pkg::*;
#(
    parameter int DW    = 128,
    parameter int AW    = 32,
    parameter int DEPTH = 4096,
    parameter int SRC_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    tl_mem_burst_if.slave  bus
);
    localparam int LB = $clog2(DW/8);
    localparam int IW = $clog2(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_word;
    logic [7:0]       r_rem;
    logic [7:0]       r_size;
    logic [SRC_W-1:0] r_source;
    logic             r_denied;

    logic [IW-1:0]    w_req_word;
    logic [7:0]       w_rem_init;
    logic             w_req_deny;
    logic             w_is_put;
    logic             w_is_get;
    logic             w_a_ready;
    logic             w_d_valid;
    logic [2:0]       w_d_opcode;
    logic             w_we;
    logic [IW-1:0]    w_waddr;
    logic [IW-1:0]    w_raddr;
    logic [DW-1:0]    w_rdata;
    logic             w_unused;

    // Word index keeps only the low IW bits so addresses wrap around DEPTH.
    assign w_req_word = bus.a_address[LB +: IW];
    assign w_rem_init = rem_init(bus.a_size, LB);
    assign w_is_put   = (bus.a_opcode == PUT_FULL) || (bus.a_opcode == PUT_PARTIAL);
    assign w_is_get   = (bus.a_opcode == GET);

`ifdef TL_MEM_DENY_EN
    localparam logic [AW:0] LIMIT = (AW+1)'(longint'(DEPTH) * longint'(DW/8));
    assign w_req_deny = ({1'b0, bus.a_address} >= LIMIT);
`else
    assign w_req_deny = 1'b0;
`endif

    assign w_unused = ^{bus.a_param, bus.a_corrupt, bus.a_address};

    always_comb begin
        w_next     = r_state;
        w_a_ready  = 1'b0;
        w_d_valid  = 1'b0;
        w_d_opcode = ACK;
        w_we       = 1'b0;
        w_waddr    = r_word;
        w_raddr    = r_word;
        case (r_state)
            IDLE: begin
                w_a_ready = 1'b1;
                w_waddr   = w_req_word;
                // Start the read of beat 0 now so it is on d_data next cycle.
                w_raddr   = w_req_word;
                if (bus.a_valid) begin
                    if (w_is_get) begin
                        w_next = RBURST;
                    end else begin
                        w_we   = w_is_put && !w_req_deny;
                        w_next = (w_is_put && (w_rem_init != 8'd0)) ? WBURST : WACK;
                    end
                end
            end
            WBURST: begin
                w_a_ready = 1'b1;
                if (bus.a_valid) begin
                    w_we = !r_denied;
                    if (r_rem == 8'd1) begin
                        w_next = WACK;
                    end
                end
            end
            WACK: begin
                w_d_valid = 1'b1;
                if (bus.d_ready) begin
                    w_next = IDLE;
                end
            end
            RBURST: begin
                w_d_valid  = 1'b1;
                w_d_opcode = ACK_DATA;
                // While stalled the RAM keeps re-reading the current word,
                // which holds d_data stable; on a handshake it fetches the next.
                if (bus.d_ready) begin
                    w_raddr = r_word + IW'(1);
                    if (r_rem == 8'd0) begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_word   <= '0;
            r_rem    <= '0;
            r_size   <= '0;
            r_source <= '0;
            r_denied <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.a_valid) begin
                        r_size   <= bus.a_size;
                        r_source <= bus.a_source;
                        r_denied <= w_req_deny;
                        r_rem    <= (w_is_put || w_is_get) ? w_rem_init : 8'd0;
                        // Writes consume beat 0 here, reads present it next.
                        r_word   <= w_is_get ? w_req_word : w_req_word + IW'(1);
                    end
                end
                WBURST: begin
                    if (bus.a_valid) begin
                        r_word <= r_word + IW'(1);
                        r_rem  <= r_rem - 8'd1;
                    end
                end
                RBURST: begin
                    if (bus.d_ready) begin
                        r_word <= r_word + IW'(1);
                        if (r_rem != 8'd0) begin
                            r_rem <= r_rem - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    tl_mem_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_we ? bus.a_mask : '0),
        .i_waddr (w_waddr),
        .i_wdata (bus.a_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.a_ready   = w_a_ready;
    assign bus.d_valid   = w_d_valid;
    assign bus.d_opcode  = w_d_opcode;
    assign bus.d_param   = 2'd0;
    assign bus.d_sink    = 3'd0;
    assign bus.d_size    = r_size;
    assign bus.d_source  = r_source;
    assign bus.d_denied  = w_d_valid && r_denied;
    assign bus.d_corrupt = (r_state == RBURST) && r_denied;
    assign bus.d_data    = ((r_state == RBURST) && !r_denied) ? w_rdata : '0;
endmodule
